// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: one single-port RAM shared between CPU accesses and
// VGA scanout prefetch, with scanout taking priority whenever its FIFO runs low.
module vga_fb_arbiter #(
    parameter int unsigned FB_AW      = 19,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [FB_AW-1:0] cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_wstrb,
    output logic             cpu_ack,
    output logic [31:0]      cpu_rdata,
    input  logic             frame_start,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [23:0]      pix_data,
    output logic             underflow,
    output logic             ram_en,
    output logic             ram_we,
    output logic [FB_AW-1:0] ram_addr,
    output logic [31:0]      ram_wdata,
    output logic [3:0]       ram_wstrb,
    input  logic [31:0]      ram_rdata
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(FIFO_DEPTH / 2);

    logic [FB_AW-1:0] ptr_q;
    logic             done_q;
    logic             fetch_q;
    logic             cpu_q;
    logic             cpu_we_q;
    logic             underflow_q;
    logic [CW-1:0]    count_q;
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [23:0]      mem_q [FIFO_DEPTH];

    logic [CW-1:0] occ;
    logic          eligible;
    logic          urgent;
    logic          grant_fetch;
    logic          grant_cpu;
    logic          push;
    logic          pop;
    logic          pop_empty;

    // Outputs are held at zero while reset is asserted.
    always_comb begin
        occ         = count_q + CW'(fetch_q);
        eligible    = reset && !done_q && !frame_start && (occ < DEPTH_C);
        urgent      = eligible && (occ < HALF_C);
        grant_fetch = 1'b0;
        grant_cpu   = 1'b0;
        if (urgent) begin
            grant_fetch = 1'b1;
        end else if (reset && cpu_req && !cpu_q) begin
            grant_cpu = 1'b1;
        end else if (eligible) begin
            grant_fetch = 1'b1;
        end
        // A fetch returning during frame_start belongs to the old frame.
        push      = fetch_q && !frame_start;
        pop       = pix_ready && (count_q != '0);
        pop_empty = pix_ready && (count_q == '0);
    end

    always_comb begin
        ram_en    = grant_fetch | grant_cpu;
        ram_we    = grant_cpu & cpu_we;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wstrb = '0;
        if (grant_cpu) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_wstrb = cpu_wstrb;
        end else if (grant_fetch) begin
            ram_addr = ptr_q;
        end
        cpu_ack   = cpu_q && reset;
        cpu_rdata = (cpu_ack && !cpu_we_q) ? ram_rdata : '0;
        pix_valid = (count_q != '0);
        pix_data  = pix_valid ? mem_q[rd_q] : '0;
        underflow = underflow_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q       <= '0;
            done_q      <= 1'b0;
            fetch_q     <= 1'b0;
            cpu_q       <= 1'b0;
            cpu_we_q    <= 1'b0;
            underflow_q <= 1'b0;
            count_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
        end else begin
            cpu_q   <= grant_cpu;
            fetch_q <= grant_fetch;
            if (grant_cpu) begin
                cpu_we_q <= cpu_we;
            end
            if (frame_start) begin
                ptr_q       <= '0;
                done_q      <= 1'b0;
                count_q     <= '0;
                rd_q        <= '0;
                wr_q        <= '0;
                underflow_q <= pop_empty;
            end else begin
                underflow_q <= underflow_q | pop_empty;
                if (grant_fetch) begin
                    if (ptr_q == LAST_ADDR) begin
                        done_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + FB_AW'(1);
                    end
                end
                if (push) begin
                    wr_q <= wr_q + PW'(1);
                end
                if (pop) begin
                    rd_q <= rd_q + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem_q[wr_q] <= ram_rdata[23:0];
        end
    end

    // Occupancy accounting must keep a returning fetch from landing in a full FIFO.
    push_when_full_a: assert property (@(posedge clock) disable iff (!reset)
        !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus a randomized run scored
// against a frame-order pixel model and a CPU-visible memory model.
module tb_vga_fb_arbiter;
    localparam int unsigned FB_AW     = 19;
    localparam int unsigned H_ACT     = 16;
    localparam int unsigned V_ACT     = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned NPIX      = H_ACT * V_ACT;
    localparam int unsigned RAM_WORDS = 8192;

    logic             clock = 1'b0;
    logic             reset;
    logic             cpu_req;
    logic             cpu_we;
    logic [FB_AW-1:0] cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [3:0]       cpu_wstrb;
    logic             cpu_ack;
    logic [31:0]      cpu_rdata;
    logic             frame_start;
    logic             pix_ready;
    logic             pix_valid;
    logic [23:0]      pix_data;
    logic             underflow;
    logic             ram_en;
    logic             ram_we;
    logic [FB_AW-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic [3:0]       ram_wstrb;
    logic [31:0]      ram_rdata;

    int checks = 0;
    int passed = 0;

    // RAM contents: word n holds n until written.
    bit [31:0] ram_mem   [RAM_WORDS];
    bit        ram_wr    [RAM_WORDS];
    bit [31:0] model_mem [RAM_WORDS];
    bit        model_wr  [RAM_WORDS];

    vga_fb_arbiter #(
        .FB_AW      (FB_AW),
        .H_ACTIVE   (H_ACT),
        .V_ACTIVE   (V_ACT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wstrb   (cpu_wstrb),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .frame_start (frame_start),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .underflow   (underflow),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wstrb   (ram_wstrb),
        .ram_rdata   (ram_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ram_get(input int unsigned a);
        return ram_wr[a] ? ram_mem[a] : a;
    endfunction

    function automatic logic [31:0] model_rd(input int unsigned a);
        return model_wr[a] ? model_mem[a] : a;
    endfunction

    function automatic void model_write(input int unsigned a, input logic [31:0] wd,
                                        input logic [3:0] strb);
        model_mem[a] = merge(model_rd(a), wd, strb);
        model_wr[a]  = 1'b1;
    endfunction

    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[int'(ram_addr[12:0])] <= merge(ram_get(int'(ram_addr[12:0])), ram_wdata,
                                                       ram_wstrb);
                ram_wr[int'(ram_addr[12:0])]  <= 1'b1;
            end else begin
                ram_rdata <= ram_get(int'(ram_addr[12:0]));
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_wstrb = '0; frame_start = 1'b0; pix_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic cpu_access(input logic we, input logic [FB_AW-1:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb,
                              output logic [31:0] rdata, output int lat);
        lat = 0;
        rdata = '0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = strb;
        for (int i = 1; i <= 100 && lat == 0; i++) begin
            @(negedge clock); #1;
            if (cpu_ack) begin
                lat = i;
                rdata = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        if (lat != 0 && we) model_write(int'(addr), wdata, strb);
    endtask

    task automatic test_reset();
        logic [31:0] w;
        reset = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h42; cpu_wdata = 32'hdead_beef; cpu_wstrb = 4'hf;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", ram_en); else passed++;
        checks++; if ({pix_valid, cpu_ack, underflow, ram_we} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {pix_valid, cpu_ack, underflow, ram_we});
        else passed++;
        checks++; if ({ram_addr, ram_wdata, ram_wstrb, pix_data, cpu_rdata} !== '0)
            $display("FAIL reset_buses: got addr=%h wdata=%h strb=%h pix=%h rdata=%h want all 0",
                     ram_addr, ram_wdata, ram_wstrb, pix_data, cpu_rdata);
        else passed++;
        @(negedge clock); reset = 1'b1; cpu_req = 1'b0; #1;
        checks++; if (!(ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === '0))
            $display("FAIL first_fetch: got en=%b we=%b addr=%h want en=1 we=0 addr=0", ram_en, ram_we, ram_addr);
        else passed++;
        @(negedge clock); #1;
        checks++; if (!(pix_valid === 1'b0 && ram_addr === 19'd1))
            $display("FAIL fetch_latency1: got valid=%b addr=%h want valid=0 addr=1", pix_valid, ram_addr);
        else passed++;
        @(negedge clock); #1;
        w = model_rd(0);
        checks++; if (!(pix_valid === 1'b1 && pix_data === w[23:0]))
            $display("FAIL fetch_latency2: got valid=%b pix=%h want valid=1 pix=%h", pix_valid, pix_data, w[23:0]);
        else passed++;
    endtask

    task automatic test_stream();
        int idx = 0;
        logic [31:0] w;
        apply_reset();
        for (int g = 0; g < 300 && idx < int'(NPIX); g++) begin
            @(negedge clock); #1;
            if (pix_valid) begin
                w = model_rd(idx);
                checks++; if (pix_data !== w[23:0])
                    $display("FAIL stream_pixel[%0d]: got %h want %h", idx, pix_data, w[23:0]);
                else passed++;
                idx++;
            end else if (idx > 0) begin
                checks++; $display("FAIL stream_gap[%0d]: got valid=0 want valid=1", idx);
            end
            pix_ready = pix_valid;
        end
        checks++; if (idx != int'(NPIX)) $display("FAIL stream_count: got %0d want %0d", idx, NPIX); else passed++;
        @(negedge clock); pix_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); #1;
            checks++; if (ram_en !== 1'b0) $display("FAIL stream_done_idle: got en=%b addr=%h want en=0", ram_en, ram_addr);
            else passed++;
        end
        checks++; if ({pix_valid, underflow} !== 2'b00)
            $display("FAIL stream_end_flags: got valid=%b underflow=%b want 0 0", pix_valid, underflow);
        else passed++;
        @(negedge clock); frame_start = 1'b1; #1;
        checks++; if (ram_en !== 1'b0) $display("FAIL fs_no_fetch: got en=%b want 0", ram_en); else passed++;
        @(negedge clock); frame_start = 1'b0; #1;
        checks++; if (!(ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === '0))
            $display("FAIL fs_restart: got en=%b addr=%h want en=1 addr=0", ram_en, ram_addr);
        else passed++;
    endtask

    task automatic test_urgent();
        logic [31:0] w;
        apply_reset();
        repeat (3) @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h55; #1;
        checks++; if (!(ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === 19'd3))
            $display("FAIL urgent_scanout_first: got en=%b we=%b addr=%h want en=1 we=0 addr=3", ram_en, ram_we, ram_addr);
        else passed++;
        @(negedge clock); #1;
        checks++; if (!(ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === 19'h55))
            $display("FAIL urgent_cpu_next: got en=%b we=%b addr=%h want en=1 we=0 addr=55", ram_en, ram_we, ram_addr);
        else passed++;
        @(negedge clock); #1;
        w = model_rd(32'h55);
        checks++; if (!(cpu_ack === 1'b1 && cpu_rdata === w))
            $display("FAIL urgent_cpu_rdata: got ack=%b rdata=%h want ack=1 rdata=%h", cpu_ack, cpu_rdata, w);
        else passed++;
        checks++; if (!(ram_en === 1'b1 && ram_addr === 19'd4))
            $display("FAIL ack_cycle_no_regrant: got en=%b addr=%h want en=1 addr=4", ram_en, ram_addr);
        else passed++;
        cpu_req = 1'b0;
    endtask

    task automatic test_cpu_full();
        logic [31:0] rd;
        int lat;
        apply_reset();
        repeat (12) @(negedge clock);
        #1;
        checks++; if (!(ram_en === 1'b0 && pix_valid === 1'b1))
            $display("FAIL full_idle: got en=%b valid=%b want en=0 valid=1", ram_en, pix_valid);
        else passed++;
        @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h100; cpu_wdata = 32'ha5a5_a5a5; cpu_wstrb = 4'hf; #1;
        checks++; if (!(ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === 19'h100 &&
                        ram_wdata === 32'ha5a5_a5a5 && ram_wstrb === 4'hf))
            $display("FAIL full_cpu_grant: got en=%b we=%b addr=%h wd=%h strb=%h want 1 1 100 a5a5a5a5 f",
                     ram_en, ram_we, ram_addr, ram_wdata, ram_wstrb);
        else passed++;
        @(negedge clock); #1;
        checks++; if (cpu_ack !== 1'b1) $display("FAIL full_cpu_ack: got %b want 1", cpu_ack); else passed++;
        cpu_req = 1'b0;
        model_write(32'h100, 32'ha5a5_a5a5, 4'hf);
        @(negedge clock); #1;
        checks++; if (!(cpu_ack === 1'b0 && ram_mem[256] === 32'ha5a5_a5a5))
            $display("FAIL full_ram_word: got ack=%b word=%h want ack=0 word=a5a5a5a5", cpu_ack, ram_mem[256]);
        else passed++;
        cpu_access(1'b1, 19'h101, 32'h1122_3344, 4'b0101, rd, lat);
        checks++; if (lat != 1) $display("FAIL strobe_write_lat: got %0d want 1", lat); else passed++;
        cpu_access(1'b0, 19'h101, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0022_0144) $display("FAIL strobe_readback: got %h want 00220144", rd); else passed++;
        cpu_access(1'b1, 19'h102, 32'hffff_ffff, 4'h0, rd, lat);
        checks++; if (lat != 1) $display("FAIL zero_strobe_ack: got lat=%0d want 1", lat); else passed++;
        cpu_access(1'b0, 19'h102, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0000_0102) $display("FAIL zero_strobe_data: got %h want 00000102", rd); else passed++;
        cpu_access(1'b0, 19'h100, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'ha5a5_a5a5) $display("FAIL full_readback: got %h want a5a5a5a5", rd); else passed++;
    endtask

    task automatic test_underflow();
        apply_reset();
        pix_ready = 1'b1; #1;
        checks++; if (pix_valid !== 1'b0) $display("FAIL uf_empty: got valid=%b want 0", pix_valid); else passed++;
        @(negedge clock); pix_ready = 1'b0; #1;
        checks++; if (underflow !== 1'b1) $display("FAIL uf_set: got %b want 1", underflow); else passed++;
        repeat (6) @(negedge clock);
        #1;
        checks++; if (!(underflow === 1'b1 && pix_valid === 1'b1))
            $display("FAIL uf_sticky: got underflow=%b valid=%b want 1 1", underflow, pix_valid);
        else passed++;
        @(negedge clock); frame_start = 1'b1; #1;
        checks++; if (ram_en !== 1'b0) $display("FAIL uf_fs_no_fetch: got en=%b want 0", ram_en); else passed++;
        @(negedge clock); frame_start = 1'b0; #1;
        checks++; if (!(underflow === 1'b0 && pix_valid === 1'b0 && ram_en === 1'b1 && ram_addr === '0))
            $display("FAIL uf_clear: got uf=%b valid=%b en=%b addr=%h want 0 0 1 0", underflow, pix_valid, ram_en, ram_addr);
        else passed++;
        @(negedge clock); frame_start = 1'b1; pix_ready = 1'b1;
        @(negedge clock); frame_start = 1'b0; pix_ready = 1'b0; #1;
        checks++; if (!(underflow === 1'b1 && pix_valid === 1'b0))
            $display("FAIL uf_fs_and_pop: got uf=%b valid=%b want 1 0", underflow, pix_valid);
        else passed++;
    endtask

    task automatic test_frame_discard();
        logic [31:0] w;
        apply_reset();
        @(negedge clock); frame_start = 1'b1; #1;
        checks++; if (ram_en !== 1'b0) $display("FAIL disc_fs_no_fetch: got en=%b want 0", ram_en); else passed++;
        @(negedge clock); frame_start = 1'b0; #1;
        checks++; if (!(ram_en === 1'b1 && ram_addr === '0 && pix_valid === 1'b0))
            $display("FAIL disc_refetch: got en=%b addr=%h valid=%b want 1 0 0", ram_en, ram_addr, pix_valid);
        else passed++;
        @(negedge clock); #1;
        checks++; if (pix_valid !== 1'b0) $display("FAIL disc_not_pushed: got valid=%b want 0", pix_valid); else passed++;
        @(negedge clock); #1;
        w = model_rd(0);
        checks++; if (!(pix_valid === 1'b1 && pix_data === w[23:0]))
            $display("FAIL disc_land: got valid=%b pix=%h want 1 %h", pix_valid, pix_data, w[23:0]);
        else passed++;
        repeat (10) @(negedge clock);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h100; #1;
        checks++; if (!(ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === 19'h100))
            $display("FAIL fs_cpu_grant: got en=%b we=%b addr=%h want 1 0 100", ram_en, ram_we, ram_addr);
        else passed++;
        @(negedge clock); frame_start = 1'b1; #1;
        w = model_rd(32'h100);
        checks++; if (!(cpu_ack === 1'b1 && cpu_rdata === w))
            $display("FAIL fs_cpu_completes: got ack=%b rdata=%h want 1 %h", cpu_ack, cpu_rdata, w);
        else passed++;
        cpu_req = 1'b0;
        @(negedge clock); frame_start = 1'b0; #1;
        checks++; if (!(pix_valid === 1'b0 && ram_en === 1'b1 && ram_addr === '0))
            $display("FAIL fs_flush: got valid=%b en=%b addr=%h want 0 1 0", pix_valid, ram_en, ram_addr);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0]      rd, w;
        int               lat, bad = 0, pidx = 0, pops = 0, acks = 0, frames = 0, wait_cnt = 0;
        logic             pend = 1'b0, pend_we = 1'b0;
        logic [FB_AW-1:0] pend_addr = '0;
        logic [31:0]      pend_wdata = '0;
        logic [3:0]       pend_strb = '0;
        for (int i = 0; i < int'(NPIX); i++) begin
            cpu_access(1'b1, FB_AW'(i), $urandom, 4'hf, rd, lat);
            if (lat == 0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL rand_preload: got %0d lost writes want 0", bad); else passed++;
        @(negedge clock); frame_start = 1'b1;
        @(negedge clock); frame_start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock); #1;
            if (cpu_ack) begin
                w = model_rd(int'(pend_addr));
                checks++;
                if (!pend) $display("FAIL rand_spurious_ack: got ack=1 want 0");
                else if (!pend_we && cpu_rdata !== w)
                    $display("FAIL rand_cpu_read[%h]: got %h want %h", pend_addr, cpu_rdata, w);
                else passed++;
                if (pend && pend_we) model_write(int'(pend_addr), pend_wdata, pend_strb);
                if (pend) acks++;
                pend = 1'b0; cpu_req = 1'b0;
            end else if (pend) begin
                wait_cnt++;
                if (wait_cnt > 64) begin
                    checks++; $display("FAIL rand_cpu_timeout[%h]: got no ack want ack within 64", pend_addr);
                    pend = 1'b0; cpu_req = 1'b0;
                end
            end
            if ((pidx == int'(NPIX) && $urandom_range(7) == 0) || $urandom_range(499) == 0) begin
                frame_start = 1'b1; pix_ready = 1'b0; pidx = 0; frames++;
            end else begin
                frame_start = 1'b0;
                pix_ready = pix_valid & 1'($urandom_range(1));
                if (pix_ready) begin
                    w = model_rd(pidx);
                    checks++;
                    if (pidx >= int'(NPIX) || pix_data !== w[23:0])
                        $display("FAIL rand_pixel[%0d]: got %h want %h", pidx, pix_data, w[23:0]);
                    else passed++;
                    pidx++; pops++;
                end
            end
            if (!pend && !cpu_req && $urandom_range(2) == 0) begin
                pend = 1'b1; wait_cnt = 0;
                pend_we = 1'($urandom_range(1));
                pend_addr = (pend_we || $urandom_range(1) == 1) ? FB_AW'(32'h1000 + $urandom_range(63))
                                                                : FB_AW'($urandom_range(NPIX - 1));
                pend_wdata = $urandom;
                pend_strb = 4'($urandom_range(15));
                cpu_req = 1'b1; cpu_we = pend_we; cpu_addr = pend_addr;
                cpu_wdata = pend_wdata; cpu_wstrb = pend_strb;
            end
        end
        @(negedge clock); cpu_req = 1'b0; pix_ready = 1'b0; frame_start = 1'b0; #1;
        checks++; if (underflow !== 1'b0) $display("FAIL rand_underflow: got %b want 0", underflow); else passed++;
        checks++; if (pops < 200 || acks < 50 || frames < 1)
            $display("FAIL rand_progress: got pops=%0d acks=%0d frames=%0d want >=200 >=50 >=1", pops, acks, frames);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_urgent();
        test_cpu_full();
        test_underflow();
        test_frame_discard();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
